// File: rtl/misere_board_engine.sv
// N x N Wild Misere engine: validates moves, writes the board, then walks four directions
// through the placed cell one step per clock to detect a losing K-in-a-row.
module misere_board_engine #(
    parameter int unsigned N  = 3,
    parameter int unsigned K  = 3,
    parameter int unsigned CW = 2
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          new_game,
    input  logic          move_valid,
    output logic          move_ready,
    input  logic [CW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    input  logic [1:0]    move_sym,
    output logic          move_reject,
    output logic [1:0]    reject_code,
    output logic          done,
    output logic          turn,
    output logic          game_over,
    output logic [1:0]    result,
    output logic [7:0]    move_count,
    input  logic [CW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_sym
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0]           LastStep = SW'(2 * K - 2);
    localparam logic signed [CW+1:0]    KMinus1  = (CW + 2)'(K - 1);
    localparam logic signed [CW+1:0]    NSigned  = (CW + 2)'(N);

    typedef enum logic [1:0] {StIdle, StScan, StEval, StOver} state_e;

    state_e        state_q, state_d;
    logic [1:0]    board_q [N][N];
    logic [1:0]    board_d [N][N];
    logic          turn_q, turn_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    result_q, result_d;
    logic [7:0]    move_count_q, move_count_d;
    logic          reject_q, reject_d;
    logic [1:0]    reject_code_q, reject_code_d;
    logic          done_q, done_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [1:0]    sym_q, sym_d;
    logic [1:0]    dir_q, dir_d;
    logic [SW-1:0] step_q, step_d;
    logic [4:0]    run_q, run_d;
    logic          loss_q, loss_d;

    logic signed [CW+1:0] off, r_s, c_s;
    logic                 on_board, hit;
    logic [4:0]           run_nx;
    logic                 in_range, bad_sym, occupied;

    // Scan probe: signed coordinates so stepping off an edge never aliases onto the board.
    always_comb begin
        off = $signed({1'b0, step_q}) - KMinus1;
        r_s = $signed({2'b00, row_q});
        c_s = $signed({2'b00, col_q});
        case (dir_q)
            2'd0:    c_s = c_s + off;
            2'd1:    r_s = r_s + off;
            2'd2: begin
                r_s = r_s + off;
                c_s = c_s + off;
            end
            default: begin
                r_s = r_s + off;
                c_s = c_s - off;
            end
        endcase
        on_board = (r_s >= 0) && (r_s < NSigned) && (c_s >= 0) && (c_s < NSigned);
        hit      = on_board && (board_q[r_s[IW-1:0]][c_s[IW-1:0]] == sym_q);
        run_nx   = hit ? (((step_q == '0) ? 5'd0 : run_q) + 5'd1) : 5'd0;
    end

    assign in_range = (move_row < CW'(N)) && (move_col < CW'(N));
    assign bad_sym  = (move_sym == 2'b00) || (move_sym == 2'b11);
    assign occupied = in_range && (board_q[move_row[IW-1:0]][move_col[IW-1:0]] != 2'b00);

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        turn_d        = turn_q;
        game_over_d   = game_over_q;
        result_d      = result_q;
        move_count_d  = move_count_q;
        reject_d      = 1'b0;
        reject_code_d = 2'b00;
        done_d        = 1'b0;
        row_d         = row_q;
        col_d         = col_q;
        sym_d         = sym_q;
        dir_d         = dir_q;
        step_d        = step_q;
        run_d         = run_q;
        loss_d        = loss_q;

        if (new_game) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    board_d[r][c] = 2'b00;
                end
            end
            state_d      = StIdle;
            turn_d       = 1'b0;
            game_over_d  = 1'b0;
            result_d     = 2'b00;
            move_count_d = 8'd0;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (move_valid) begin
                        if (game_over_q) begin
                            reject_d      = 1'b1;
                            reject_code_d = 2'b00;
                        end else if (!in_range) begin
                            reject_d      = 1'b1;
                            reject_code_d = 2'b01;
                        end else if (bad_sym) begin
                            reject_d      = 1'b1;
                            reject_code_d = 2'b11;
                        end else if (occupied) begin
                            reject_d      = 1'b1;
                            reject_code_d = 2'b10;
                        end else begin
                            board_d[move_row[IW-1:0]][move_col[IW-1:0]] = move_sym;
                            move_count_d = move_count_q + 8'd1;
                            row_d        = move_row;
                            col_d        = move_col;
                            sym_d        = move_sym;
                            dir_d        = 2'd0;
                            step_d       = '0;
                            run_d        = 5'd0;
                            loss_d       = 1'b0;
                            state_d      = StScan;
                        end
                    end
                end
                StScan: begin
                    run_d = run_nx;
                    if (run_nx == 5'(K)) begin
                        loss_d = 1'b1;
                    end
                    if (step_q == LastStep) begin
                        step_d = '0;
                        if (dir_q == 2'd3) begin
                            state_d = StEval;
                        end else begin
                            dir_d = dir_q + 2'd1;
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                StEval: begin
                    done_d = 1'b1;
                    if (loss_q) begin
                        game_over_d = 1'b1;
                        result_d    = turn_q ? 2'b01 : 2'b10;
                        state_d     = StOver;
                    end else if (move_count_q == 8'(N * N)) begin
                        game_over_d = 1'b1;
                        result_d    = 2'b11;
                        state_d     = StOver;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    board_q[r][c] <= 2'b00;
                end
            end
            state_q       <= StIdle;
            turn_q        <= 1'b0;
            game_over_q   <= 1'b0;
            result_q      <= 2'b00;
            move_count_q  <= 8'd0;
            reject_q      <= 1'b0;
            reject_code_q <= 2'b00;
            done_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            sym_q         <= 2'b00;
            dir_q         <= 2'd0;
            step_q        <= '0;
            run_q         <= 5'd0;
            loss_q        <= 1'b0;
        end else begin
            board_q       <= board_d;
            state_q       <= state_d;
            turn_q        <= turn_d;
            game_over_q   <= game_over_d;
            result_q      <= result_d;
            move_count_q  <= move_count_d;
            reject_q      <= reject_d;
            reject_code_q <= reject_code_d;
            done_q        <= done_d;
            row_q         <= row_d;
            col_q         <= col_d;
            sym_q         <= sym_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            run_q         <= run_d;
            loss_q        <= loss_d;
        end
    end

    assign move_ready  = (state_q == StIdle) || (state_q == StOver);
    assign move_reject = reject_q;
    assign reject_code = reject_code_q;
    assign done        = done_q;
    assign turn        = turn_q;
    assign game_over   = game_over_q;
    assign result      = result_q;
    assign move_count  = move_count_q;
    assign rd_sym      = ((rd_row < CW'(N)) && (rd_col < CW'(N))) ?
                         board_q[rd_row[IW-1:0]][rd_col[IW-1:0]] : 2'b00;

endmodule

// File: tb/tb_misere_board_engine.sv
// Directed bench: three engines (N3K3, N3K2, N5K4) share move/read buses; each has its own
// move_valid so moves can be steered to one engine at a time.
module tb_misere_board_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic       new_game;
    logic       valid [3];
    logic [2:0] row, col, rd_row, rd_col;
    logic [1:0] sym;
    logic       ready [3];
    logic       rej [3];
    logic       done [3];
    logic       turn [3];
    logic       gover [3];
    logic [1:0] code [3];
    logic [1:0] res [3];
    logic [1:0] rd_sym [3];
    logic [7:0] cnt [3];

    int exp_lat [3] = '{22, 14, 30};
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    misere_board_engine #(.N(3), .K(3), .CW(3)) u_n3k3 (
        .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(valid[0]),
        .move_ready(ready[0]), .move_row(row), .move_col(col), .move_sym(sym),
        .move_reject(rej[0]), .reject_code(code[0]), .done(done[0]), .turn(turn[0]),
        .game_over(gover[0]), .result(res[0]), .move_count(cnt[0]), .rd_row(rd_row),
        .rd_col(rd_col), .rd_sym(rd_sym[0])
    );

    misere_board_engine #(.N(3), .K(2), .CW(3)) u_n3k2 (
        .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(valid[1]),
        .move_ready(ready[1]), .move_row(row), .move_col(col), .move_sym(sym),
        .move_reject(rej[1]), .reject_code(code[1]), .done(done[1]), .turn(turn[1]),
        .game_over(gover[1]), .result(res[1]), .move_count(cnt[1]), .rd_row(rd_row),
        .rd_col(rd_col), .rd_sym(rd_sym[1])
    );

    misere_board_engine #(.N(5), .K(4), .CW(3)) u_n5k4 (
        .clock(clock), .resetn(resetn), .new_game(new_game), .move_valid(valid[2]),
        .move_ready(ready[2]), .move_row(row), .move_col(col), .move_sym(sym),
        .move_reject(rej[2]), .reject_code(code[2]), .done(done[2]), .turn(turn[2]),
        .game_over(gover[2]), .result(res[2]), .move_count(cnt[2]), .rd_row(rd_row),
        .rd_col(rd_col), .rd_sym(rd_sym[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request; lat = negedges after the accept edge until done (0 if none/rejected).
    task automatic mv(input int u, input int r, input int c, input int s, output int lat,
                      output int low, output logic rj, output logic [1:0] cd);
        @(negedge clock);
        row = 3'(r);
        col = 3'(c);
        sym = 2'(s);
        valid[u] = 1'b1;
        @(negedge clock);
        valid[u] = 1'b0;
        lat = 0;
        low = 0;
        rj  = rej[u];
        cd  = code[u];
        if (!rj) begin
            for (int j = 1; j < 200; j++) begin
                if (done[u]) begin
                    lat = j;
                    break;
                end
                if (!ready[u]) low++;
                @(negedge clock);
            end
        end
    endtask

    task automatic play(input int u, input int r, input int c, input int s);
        int lat, low;
        logic rj;
        logic [1:0] cd;
        mv(u, r, c, s, lat, low, rj, cd);
        chk($sformatf("u%0d accept (%0d,%0d)", u, r, c), {31'b0, rj}, 32'd0);
        chk($sformatf("u%0d latency (%0d,%0d)", u, r, c), lat, exp_lat[u]);
        chk($sformatf("u%0d busy cycles (%0d,%0d)", u, r, c), low, exp_lat[u] - 1);
    endtask

    task automatic refuse(input string tag, input int u, input int r, input int c, input int s,
                          input int ecode, input int eturn, input int ecnt);
        int lat, low;
        logic rj;
        logic [1:0] cd;
        mv(u, r, c, s, lat, low, rj, cd);
        chk({tag, " reject"}, {31'b0, rj}, 32'd1);
        chk({tag, " code"}, {30'b0, cd}, ecode);
        chk({tag, " ready"}, {31'b0, ready[u]}, 32'd1);
        chk({tag, " turn"}, {31'b0, turn[u]}, eturn);
        chk({tag, " count"}, {24'b0, cnt[u]}, ecnt);
    endtask

    task automatic ng();
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
    endtask

    task automatic rd(input string tag, input int u, input int r, input int c, input int exp);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        chk(tag, {30'b0, rd_sym[u]}, exp);
    endtask

    // Launch a move on u0, abort mid-scan with new_game (kind 0) or resetn (kind 1).
    task automatic interrupt(input string tag, input int kind);
        logic seen;
        ng();
        @(negedge clock);
        row = 3'd1;
        col = 3'd1;
        sym = 2'd1;
        valid[0] = 1'b1;
        @(negedge clock);
        valid[0] = 1'b0;
        repeat (5) @(negedge clock);
        if (kind == 0) new_game = 1'b1;
        else           resetn   = 1'b0;
        @(negedge clock);
        new_game = 1'b0;
        resetn   = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            seen |= done[0];
            @(negedge clock);
        end
        chk({tag, " no done"}, {31'b0, seen}, 32'd0);
        rd({tag, " cell (1,1)"}, 0, 1, 1, 0);
        chk({tag, " turn"}, {31'b0, turn[0]}, 32'd0);
        chk({tag, " count"}, {24'b0, cnt[0]}, 32'd0);
        chk({tag, " ready"}, {31'b0, ready[0]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        new_game = 1'b0;
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        row = 3'd0;
        col = 3'd0;
        sym = 2'd0;
        rd_row = 3'd0;
        rd_col = 3'd0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        chk("reset ready", {31'b0, ready[0]}, 32'd1);
        chk("reset turn", {31'b0, turn[0]}, 32'd0);
        chk("reset game_over", {31'b0, gover[0]}, 32'd0);
        chk("reset result", {30'b0, res[0]}, 32'd0);
        chk("reset count", {24'b0, cnt[0]}, 32'd0);
        chk("reset done", {31'b0, done[0]}, 32'd0);
        chk("reset reject", {31'b0, rej[0]}, 32'd0);
        rd("reset cell", 0, 0, 0, 0);

        // Row-0 run of B completed by player 1.
        play(0, 0, 0, 1);
        chk("t1 turn after 1", {31'b0, turn[0]}, 32'd1);
        play(0, 1, 1, 2);
        play(0, 0, 1, 1);
        play(0, 2, 2, 2);
        chk("t1 no loss yet", {31'b0, gover[0]}, 32'd0);
        play(0, 0, 2, 1);
        chk("t1 done high", {31'b0, done[0]}, 32'd1);
        chk("t1 result", {30'b0, res[0]}, 32'd2);
        chk("t1 game_over", {31'b0, gover[0]}, 32'd1);
        chk("t1 count", {24'b0, cnt[0]}, 32'd5);
        @(negedge clock);
        chk("t1 done one cycle", {31'b0, done[0]}, 32'd0);
        refuse("t1 after over", 0, 1, 0, 1, 0, 0, 5);

        // Full board, no line of three.
        ng();
        chk("ng count", {24'b0, cnt[0]}, 32'd0);
        chk("ng game_over", {31'b0, gover[0]}, 32'd0);
        rd("ng cell", 0, 0, 0, 0);
        play(0, 0, 0, 1);
        play(0, 0, 1, 1);
        play(0, 0, 2, 2);
        play(0, 1, 0, 2);
        play(0, 1, 1, 2);
        play(0, 1, 2, 1);
        play(0, 2, 0, 1);
        play(0, 2, 1, 1);
        chk("t2 no over at 8", {31'b0, gover[0]}, 32'd0);
        play(0, 2, 2, 2);
        chk("t2 result tie", {30'b0, res[0]}, 32'd3);
        chk("t2 game_over", {31'b0, gover[0]}, 32'd1);
        chk("t2 count", {24'b0, cnt[0]}, 32'd9);
        chk("t2 turn", {31'b0, turn[0]}, 32'd0);
        rd("t2 cell (2,2)", 0, 2, 2, 2);
        rd("t2 cell (1,2)", 0, 1, 2, 1);
        rd("t2 read row oob", 0, 3, 0, 0);
        rd("t2 read col oob", 0, 0, 3, 0);

        // Rejection priority.
        ng();
        play(0, 1, 1, 1);
        refuse("t3 occupied", 0, 1, 1, 2, 2, 1, 1);
        refuse("t3 range", 0, 3, 0, 1, 1, 1, 1);
        refuse("t3 sym00", 0, 0, 0, 0, 3, 1, 1);
        refuse("t3 range over sym", 0, 3, 0, 3, 1, 1, 1);
        refuse("t3 sym11", 0, 2, 2, 3, 3, 1, 1);

        // K=2: 13-cycle scan; second B next to the first loses for player 2.
        ng();
        play(1, 0, 0, 1);
        play(1, 0, 1, 1);
        chk("k2 result", {30'b0, res[1]}, 32'd1);
        chk("k2 game_over", {31'b0, gover[1]}, 32'd1);

        // N=5, K=4 anti-diagonal loss across mixed players.
        ng();
        play(2, 0, 4, 1);
        play(2, 1, 3, 1);
        play(2, 2, 2, 1);
        chk("t5 no loss at 3", {31'b0, gover[2]}, 32'd0);
        play(2, 3, 1, 1);
        chk("t5 result", {30'b0, res[2]}, 32'd1);
        chk("t5 game_over", {31'b0, gover[2]}, 32'd1);

        // Edge-adjacent cells that would form runs only if the scan wrapped.
        ng();
        play(2, 3, 3, 1);
        play(2, 3, 4, 1);
        play(2, 4, 0, 1);
        play(2, 4, 1, 1);
        play(2, 4, 3, 1);
        play(2, 4, 4, 1);
        play(2, 0, 0, 1);
        chk("t5 wrap game_over", {31'b0, gover[2]}, 32'd0);
        chk("t5 wrap count", {24'b0, cnt[2]}, 32'd7);
        chk("t5 wrap turn", {31'b0, turn[2]}, 32'd1);

        interrupt("t6 new_game", 0);
        interrupt("t6 resetn", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
